// File: rtl/spi_master_initiator.sv
// spi_master_initiator: host-side SPI mode-0 master for two-frame
// register transactions ({wr,addr} then data/dummy) under one CS_N.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_start, i_wr         transaction request (IDLE only), direction
//   i_addr, i_wdata       register address and write data
//   o_rdata, o_ack_err    frame-2 MISO byte, write-ack mismatch flag
//   o_busy, o_done        in-flight flag, 1-cycle completion pulse
//   o_spi_cs_n/sclk/mosi  SPI outputs, i_spi_miso SPI input
module spi_master_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYCLES = 8,
  parameter logic [DATA_WIDTH-1:0] P_ACK = 8'hAA
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-2:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ack_err,
  output logic                  o_spi_cs_n,
  output logic                  o_spi_sclk,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso
);

  localparam int CNT_MAX =
    (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(CNT_MAX);
  localparam int BW =
    (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT_ADDR,
    S_GAP,
    S_SHIFT_DATA,
    S_CS_HOLD,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] f2_q, f2_d;
  logic                  wr_q, wr_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ack_err_q, ack_err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // MOSI is the MSB of the shift register; it is only shifted
  // on the edge that drops SCLK, so MOSI never moves while SCLK=1.
  assign o_spi_mosi = sh_q[DATA_WIDTH-1];
  assign o_spi_cs_n = cs_n_q;
  assign o_spi_sclk = sclk_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_ack_err  = ack_err_q;
  assign o_rdata    = rdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    f2_d      = f2_q;
    wr_d      = wr_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          wr_d    = i_wr;
          f2_d    = i_wr ? i_wdata : '0;
          sh_d    = {i_wr, i_addr};
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT_ADDR;
        end
      end
      S_SHIFT_ADDR, S_SHIFT_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising SCLK: capture MISO on the same edge.
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_WIDTH-2:0], i_spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
              if (state_q == S_SHIFT_ADDR) begin
                sh_d    = f2_q;
                state_d = S_GAP;
              end else begin
                sh_d    = '0;
                state_d = S_CS_HOLD;
              end
            end else begin
              bit_d = bit_q + 1'b1;
              sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT_DATA;
        end
      end
      S_CS_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d     = '0;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rdata_d   = rx_q;
          ack_err_d = wr_q & (rx_q != P_ACK);
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      rx_q      <= '0;
      f2_q      <= '0;
      wr_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rx_q      <= rx_d;
      f2_q      <= f2_d;
      wr_q      <= wr_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_spi_master_initiator.sv
// tb_spi_master_initiator: bench for spi_master_initiator with an
// SPI register-slave model and a cycle-level reference model.
module tb_spi_master_initiator;

  localparam int C = 4;
  localparam int G = 8;
  localparam int L = 34 * C + G;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       i_wr;
  logic [6:0] i_addr;
  logic [7:0] i_wdata;
  logic [7:0] o_rdata;
  logic       o_busy;
  logic       o_done;
  logic       o_ack_err;
  logic       o_spi_cs_n;
  logic       o_spi_sclk;
  logic       o_spi_mosi;
  logic       i_spi_miso;

  spi_master_initiator dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_wr       (i_wr),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_ack_err  (o_ack_err),
    .o_spi_cs_n (o_spi_cs_n),
    .o_spi_sclk (o_spi_sclk),
    .o_spi_mosi (o_spi_mosi),
    .i_spi_miso (i_spi_miso)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Slave environment: register file, write response, ACK byte.
  logic [7:0] regs [0:127];
  logic [7:0] wr_resp = 8'hAA;
  logic [7:0] ack_b = 8'hAA;

  int          s_cnt = 0;
  logic [15:0] s_rx = '0;
  logic [7:0]  s_resp = '0;
  int          sclk_pulses = 0;

  always @(negedge o_spi_cs_n) begin
    s_cnt = 0;
    s_rx = '0;
    i_spi_miso = ack_b[7];
  end

  always @(posedge o_spi_sclk) begin
    s_rx = {s_rx[14:0], o_spi_mosi};
    s_cnt++;
    sclk_pulses++;
    if (s_cnt == 8)
      s_resp = s_rx[7] ? wr_resp : regs[s_rx[6:0]];
  end

  always @(negedge o_spi_sclk) begin
    if (s_cnt < 8) i_spi_miso = ack_b[7 - s_cnt];
    else if (s_cnt < 16) i_spi_miso = s_resp[15 - s_cnt];
    else i_spi_miso = 1'b0;
  end

  // Reference model: k = cycles since acceptance (0 = idle).
  int         k = 0;
  logic       m_wr = 0;
  logic [7:0] m_f1 = 0, m_f2 = 0, m_resp = 0;
  logic [7:0] m_rdata = 0;
  logic       m_ack = 0;

  always @(posedge i_clk) begin
    if (!i_rst) begin
      k = 0;
      m_rdata = 0;
      m_ack = 0;
    end else if (k == 0) begin
      if (i_start) begin
        k = 1;
        m_wr = i_wr;
        m_f1 = {i_wr, i_addr};
        m_f2 = i_wr ? i_wdata : 8'h00;
        m_resp = i_wr ? wr_resp : regs[i_addr];
      end
    end else if (k == L + 1) begin
      k = 0;
    end else begin
      k++;
      if (k == L + 1) begin
        m_rdata = m_resp;
        m_ack = m_wr && (m_resp != 8'hAA);
      end
    end
  end

  function automatic void model_out(
    input int kk, input logic [7:0] f1, input logic [7:0] f2,
    output logic e_cs, output logic e_sclk, output logic e_busy,
    output logic e_done, output logic e_mosi, output bit mv);
    int p;
    e_cs = 1; e_sclk = 0; e_busy = 0; e_done = 0; e_mosi = 0; mv = 0;
    if (kk >= 1 && kk <= L) begin e_cs = 0; e_busy = 1; end
    if (kk == L + 1) e_done = 1;
    p = kk - 1;
    if (kk >= 1) begin
      if (p < C) begin
        mv = 1; e_mosi = f1[7];
      end else if (p < 17 * C) begin
        p = p - C;
        mv = 1;
        e_mosi = f1[7 - p / (2 * C)];
        e_sclk = (p % (2 * C)) >= C;
      end else if (p < 17 * C + G) begin
        mv = 1; e_mosi = f2[7];
      end else if (p < 33 * C + G) begin
        p = p - (17 * C + G);
        mv = 1;
        e_mosi = f2[7 - p / (2 * C)];
        e_sclk = (p % (2 * C)) >= C;
      end
    end
  endfunction

  always @(negedge i_clk) begin
    logic e_cs, e_sclk, e_busy, e_done, e_mosi;
    bit mv;
    if (chk_en) begin
      model_out(k, m_f1, m_f2, e_cs, e_sclk, e_busy, e_done, e_mosi, mv);
      chk("cs_n", o_spi_cs_n, e_cs);
      chk("sclk", o_spi_sclk, e_sclk);
      chk("busy", o_busy, e_busy);
      chk("done", o_done, e_done);
      if (mv) chk("mosi", o_spi_mosi, e_mosi);
      chk("rdata", o_rdata, m_rdata);
      chk("ack_err", o_ack_err, m_ack);
      if (k == L + 1) begin
        chk("slave_f1", s_rx[15:8], m_f1);
        chk("slave_f2", s_rx[7:0], m_f2);
      end
    end
  end

  task automatic run_txn(input logic w, input logic [6:0] a,
                         input logic [7:0] d, input bit lit,
                         input logic [7:0] er, input logic ea,
                         input bit spur);
    int n, csl, shi, dn;
    bit seen;
    n = 0; csl = 0; shi = 0; dn = 0; seen = 0;
    sclk_pulses = 0;
    i_wr = w; i_addr = a; i_wdata = d; i_start = 1;
    while (!seen && n < 400) begin
      @(negedge i_clk);
      i_start = 0;
      n++;
      if (n == 1) begin
        i_wr = 1'($urandom); i_addr = 7'($urandom);
        i_wdata = 8'($urandom);
      end
      if (spur && n == 20) i_start = 1;
      if (!o_spi_cs_n) csl++;
      if (o_spi_sclk) shi++;
      if (o_done) begin seen = 1; dn++; end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", n, L + 1);
      chk("cs_low_cycles", csl, 144);
      chk("sclk_high_cycles", shi, 64);
      chk("sclk_pulses", sclk_pulses, 16);
      if (lit) begin
        chk("lit_rdata", o_rdata, er);
        chk("lit_ack_err", o_ack_err, ea);
      end
      if (spur) i_start = 1;
      repeat (4) begin
        @(negedge i_clk);
        i_start = 0;
        if (o_done) dn++;
      end
      chk("done_pulses", dn, 1);
      chk("sclk_pulses_after", sclk_pulses, 16);
    end
  endtask

  int n;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 0; i_start = 0; i_wr = 0; i_addr = 0; i_wdata = 0;
    i_spi_miso = 0;
    for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
    repeat (2) @(negedge i_clk);
    chk("rst_cs_n", o_spi_cs_n, 1);
    chk("rst_sclk", o_spi_sclk, 0);
    chk("rst_mosi", o_spi_mosi, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_ack_err", o_ack_err, 0);
    chk_en = 1;
    @(negedge i_clk);
    i_rst = 1;
    @(negedge i_clk);

    // 1) write with normal ACK
    wr_resp = 8'hAA;
    run_txn(1, 7'h05, 8'h3C, 1, 8'hAA, 0, 0);
    chk("t1_mosi_f1", s_rx[15:8], 8'h85);
    chk("t1_mosi_f2", s_rx[7:0], 8'h3C);

    // 2) read
    regs[7'h12] = 8'hC7;
    run_txn(0, 7'h12, 8'h99, 1, 8'hC7, 0, 0);
    chk("t2_mosi_f1", s_rx[15:8], 8'h12);
    chk("t2_mosi_f2", s_rx[7:0], 8'h00);

    // 3) write with bad ACK, then a read clears it
    wr_resp = 8'h00;
    run_txn(1, 7'h33, 8'h5A, 1, 8'h00, 1, 0);
    wr_resp = 8'hAA;
    run_txn(0, 7'h12, 8'h00, 1, 8'hC7, 0, 0);

    // 4) start pulses while busy and during DONE
    regs[7'h40] = 8'h5E;
    run_txn(0, 7'h40, 8'h11, 1, 8'h5E, 0, 1);

    // 5) reset during SHIFT_DATA bit 3
    i_wr = 1; i_addr = 7'h21; i_wdata = 8'hE4; i_start = 1; n = 0;
    while (n < 17 * C + G + 24 + 1) begin
      @(negedge i_clk);
      i_start = 0;
      n++;
    end
    i_rst = 0;
    @(negedge i_clk);
    chk("t5_cs_n", o_spi_cs_n, 1);
    chk("t5_sclk", o_spi_sclk, 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_rdata", o_rdata, 0);
    chk("t5_mosi", o_spi_mosi, 0);
    i_rst = 1;
    @(negedge i_clk);
    run_txn(1, 7'h7F, 8'hFF, 1, 8'hAA, 0, 0);
    chk("t5_mosi_f1", s_rx[15:8], 8'hFF);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic w;
      logic [6:0] a;
      logic [7:0] d;
      w = 1'($urandom);
      a = 7'($urandom);
      d = 8'($urandom);
      wr_resp = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hAA;
      regs[a] = 8'($urandom);
      run_txn(w, a, d, 0, 8'h00, 0, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
